// File: rtl/tcdm_traffic_responder.sv
// rtl/tcdm_traffic_responder.sv - TCDM responder: word storage, fixed-latency pipeline, response FIFO.
// Optional macro TCDM_RESPONDER_STALL_EN adds LFSR-driven pseudo-random request stalls.
module tcdm_traffic_responder #(
  parameter int          NumWords  = 1024,
  parameter int          DataWidth = 32,
  parameter int          AddrWidth = 32,
  parameter int          IdWidth   = 10,
  parameter int          Latency   = 2,
  parameter int          RespDepth = 4,
  parameter logic [15:0] StallSeed = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_tgt_addr_i,
  input  logic                   req_wen_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  input  logic [3:0]             req_amo_i,
  input  logic [IdWidth-1:0]     req_id_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [DataWidth-1:0]   resp_rdata_o,
  output logic [IdWidth-1:0]     resp_id_o,
  output logic [31:0]            num_req_o,
  output logic [31:0]            num_amo_o
);

  localparam int BeW  = DataWidth / 8;
  localparam int OffW = $clog2(BeW);
  localparam int IdxW = $clog2(NumWords);
  localparam int PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int CntW = $clog2(RespDepth + 1);

  logic [DataWidth-1:0] mem [NumWords];
  logic [IdxW-1:0]      idx;
  logic                 accept;
  logic                 is_write;
  logic [DataWidth-1:0] acc_data;
  logic                 unused_addr;

  assign idx         = req_tgt_addr_i[OffW +: IdxW];
  assign unused_addr = ^req_tgt_addr_i;
  assign accept      = req_valid_i && req_ready_o;
  assign is_write    = req_wen_i && (req_amo_i == 4'h0);
  assign acc_data    = is_write ? '0 : mem[idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) mem[i] <= '0;
    end else if (accept && is_write) begin
      for (int b = 0; b < BeW; b++) begin
        if (req_be_i[b]) mem[idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
      end
    end
  end

  // Fixed-latency shift pipeline; it never stalls because ready accounts for its occupancy.
  logic [Latency-1:0]   pipe_valid;
  logic [IdWidth-1:0]   pipe_id   [Latency];
  logic [DataWidth-1:0] pipe_data [Latency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      for (int i = 0; i < Latency; i++) begin
        pipe_id[i]   <= '0;
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_id[0]    <= req_id_i;
      pipe_data[0]  <= acc_data;
      for (int i = 1; i < Latency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  logic [IdWidth-1:0]   fifo_id   [RespDepth];
  logic [DataWidth-1:0] fifo_data [RespDepth];
  logic [PtrW-1:0]      wptr, rptr;
  logic [CntW-1:0]      count;
  logic                 push, pop;

  assign push         = pipe_valid[Latency-1];
  assign resp_valid_o = (count != '0);
  assign pop          = resp_valid_o && resp_ready_i;
  assign resp_id_o    = fifo_id[rptr];
  assign resp_rdata_o = fifo_data[rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < RespDepth; i++) begin
        fifo_id[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_id[wptr]   <= pipe_id[Latency-1];
        fifo_data[wptr] <= pipe_data[Latency-1];
        wptr            <= (wptr == PtrW'(RespDepth - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= (rptr == PtrW'(RespDepth - 1)) ? '0 : rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  logic [31:0] inflight;
  logic        ready_base;
  logic        stall;

  always_comb begin
    inflight = 32'(count);
    for (int i = 0; i < Latency; i++) inflight = inflight + 32'(pipe_valid[i]);
  end

  assign ready_base = inflight < 32'(RespDepth);

`ifdef TCDM_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= StallSeed;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = &lfsr[1:0];
`else
  assign stall = 1'b0;
`endif

  assign req_ready_o = rst_ni && !stall && ready_base;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_req_o <= '0;
      num_amo_o <= '0;
    end else if (accept) begin
      num_req_o <= num_req_o + 32'd1;
      if (req_amo_i != 4'h0) num_amo_o <= num_amo_o + 32'd1;
    end
  end

endmodule
